wb_mem_arbiter: RTL and testbench

//  Two-master, one-slave Wishbone (pipelined, single-outstanding) arbiter placed in

---
 rtl/wb_mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_mem_arbiter
// Purpose  : Two-master / one-slave pipelined Wishbone arbiter for the shared
//            main memory. Each master request lands in a one-entry pending
//            buffer. Requests go to memory one at a time (single outstanding),
//            with round-robin priority between masters. A slave that never
//            acks is cut off after TIMEOUT cycles with an all-ones error reply.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_mN_stb/we/addr/     master N request (N = 0 cpu, 1 loader/debug);
//     data/sel              stb is a one-cycle pulse, ignored while stalled
//   o_mN_data/ack         master N read data + one-cycle completion pulse
//   o_mN_stall            master N buffer full, do not strobe
//   o_s_stb/we/addr/      granted request towards memory (stb one cycle)
//     data/sel
//   i_s_data/ack/stall    memory read data, completion pulse, back-pressure
//   o_grant               master owning the current or last transaction
//   o_busy                a memory transaction is outstanding
//   o_timeout             one-cycle pulse when the ack timer expires
// ============================================================================
module wb_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // master 0
  input  logic              i_m0_stb,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_data,
  input  logic [SEL_W-1:0]  i_m0_sel,
  output logic [DATA_W-1:0] o_m0_data,
  output logic              o_m0_ack,
  output logic              o_m0_stall,
  // master 1
  input  logic              i_m1_stb,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_data,
  input  logic [SEL_W-1:0]  i_m1_sel,
  output logic [DATA_W-1:0] o_m1_data,
  output logic              o_m1_ack,
  output logic              o_m1_stall,
  // slave
  output logic              o_s_stb,
  output logic              o_s_we,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_data,
  output logic [SEL_W-1:0]  o_s_sel,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_ack,
  input  logic              i_s_stall,
  // status
  output logic              o_grant,
  output logic              o_busy,
  output logic              o_timeout
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Timer only needs to reach TIMEOUT-1; with TIMEOUT==0 it free-runs unused.
  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  state_t            state_q;
  logic [1:0]        pend_q;
  logic [1:0]        we_q;
  logic [ADDR_W-1:0] addr_q  [2];
  logic [DATA_W-1:0] wdata_q [2];
  logic [SEL_W-1:0]  sel_q   [2];
  logic [DATA_W-1:0] rdata_q [2];
  logic [1:0]        ack_q;
  logic              last_q;
  logic [TMR_W-1:0]  timer_q;

  // Master inputs gathered into arrays so capture is one loop.
  logic [1:0]        req_stb;
  logic [1:0]        req_we;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [SEL_W-1:0]  req_sel   [2];

  logic              gnt_d;
  logic              expire_d;

  assign req_stb      = {i_m1_stb, i_m0_stb};
  assign req_we       = {i_m1_we, i_m0_we};
  assign req_addr[0]  = i_m0_addr;
  assign req_addr[1]  = i_m1_addr;
  assign req_wdata[0] = i_m0_data;
  assign req_wdata[1] = i_m1_data;
  assign req_sel[0]   = i_m0_sel;
  assign req_sel[1]   = i_m1_sel;

  // Single pending master wins outright; on a tie the one not served last wins.
  always_comb begin
    gnt_d = pend_q[1];
    if (&pend_q) begin
      gnt_d = ~last_q;
    end
  end

  assign expire_d = TMO_EN && (timer_q == TMR_LAST);

  assign o_m0_data  = rdata_q[0];
  assign o_m1_data  = rdata_q[1];
  assign o_m0_ack   = ack_q[0];
  assign o_m1_ack   = ack_q[1];
  // Stall is the buffer-full flag; it drops in the same cycle as the ack.
  assign o_m0_stall = pend_q[0];
  assign o_m1_stall = pend_q[1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      we_q      <= '0;
      for (int n = 0; n < 2; n++) begin
        addr_q[n]  <= '0;
        wdata_q[n] <= '0;
        sel_q[n]   <= '0;
        rdata_q[n] <= '1;
      end
      ack_q     <= '0;
      last_q    <= 1'b1;
      timer_q   <= '0;
      o_s_stb   <= 1'b0;
      o_s_we    <= 1'b0;
      o_s_addr  <= '1;
      o_s_data  <= '1;
      o_s_sel   <= '0;
      o_grant   <= 1'b0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      ack_q     <= '0;
      o_timeout <= 1'b0;
      o_s_stb   <= 1'b0;

      // A strobe is only accepted into an empty buffer. The buffer being
      // completed below is never empty, so capture and clear cannot collide.
      for (int n = 0; n < 2; n++) begin
        if (req_stb[n] && !pend_q[n]) begin
          pend_q[n]  <= 1'b1;
          we_q[n]    <= req_we[n];
          addr_q[n]  <= req_addr[n];
          wdata_q[n] <= req_wdata[n];
          sel_q[n]   <= req_sel[n];
        end
      end

      case (state_q)
        S_IDLE: begin
          if (|pend_q && !i_s_stall) begin
            o_s_stb  <= 1'b1;
            o_s_we   <= we_q[gnt_d];
            o_s_addr <= addr_q[gnt_d];
            o_s_data <= wdata_q[gnt_d];
            o_s_sel  <= sel_q[gnt_d];
            o_grant  <= gnt_d;
            o_busy   <= 1'b1;
            timer_q  <= '0;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A real ack beats a simultaneous timer expiry.
          if (i_s_ack || expire_d) begin
            ack_q[o_grant]   <= 1'b1;
            rdata_q[o_grant] <= i_s_ack ? i_s_data : '1;
            pend_q[o_grant]  <= 1'b0;
            last_q           <= o_grant;
            o_busy           <= 1'b0;
            o_timeout        <= !i_s_ack;
            timer_q          <= '0;
            state_q          <= S_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_mem_arbiter
// Purpose  : Self-checking bench for wb_mem_arbiter: vector table of single
//            transactions, hand-written multi-cycle sequences (contention,
//            alternation, slave stall, timeout, mid-transaction reset) and a
//            randomized run checked against a transaction-rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_mem_arbiter;

  localparam int TMO = 4;

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  sel;
    logic [31:0] rdata;
    int          dly;       // cycles before slave ack; -1 = never
    logic [31:0] exp_data;
    bit          exp_to;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  sel;
  } req_t;

  logic        clk;
  logic        rst;
  logic [1:0]  m_stb;
  logic [1:0]  m_we;
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [2:0]  m_sel   [2];
  logic [31:0] s_rdata;
  logic        s_ack;
  logic        s_stall;

  wire [31:0] m0_rd, m1_rd;
  wire        m0_ack, m1_ack, m0_stall, m1_stall;
  wire        s_stb, s_we;
  wire [31:0] s_addr, s_data;
  wire [2:0]  s_sel;
  wire        grant, busy, tmo_o;

  wire [1:0]  ack_v   = {m1_ack, m0_ack};
  wire [1:0]  stall_v = {m1_stall, m0_stall};
  wire [31:0] rd_v [2];
  assign rd_v[0] = m0_rd;
  assign rd_v[1] = m1_rd;

  wb_mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .SEL_W  (3),
    .TIMEOUT(TMO)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_m0_stb  (m_stb[0]),
    .i_m0_we   (m_we[0]),
    .i_m0_addr (m_addr[0]),
    .i_m0_data (m_wdata[0]),
    .i_m0_sel  (m_sel[0]),
    .o_m0_data (m0_rd),
    .o_m0_ack  (m0_ack),
    .o_m0_stall(m0_stall),
    .i_m1_stb  (m_stb[1]),
    .i_m1_we   (m_we[1]),
    .i_m1_addr (m_addr[1]),
    .i_m1_data (m_wdata[1]),
    .i_m1_sel  (m_sel[1]),
    .o_m1_data (m1_rd),
    .o_m1_ack  (m1_ack),
    .o_m1_stall(m1_stall),
    .o_s_stb   (s_stb),
    .o_s_we    (s_we),
    .o_s_addr  (s_addr),
    .o_s_data  (s_data),
    .o_s_sel   (s_sel),
    .i_s_data  (s_rdata),
    .i_s_ack   (s_ack),
    .i_s_stall (s_stall),
    .o_grant   (grant),
    .o_busy    (busy),
    .o_timeout (tmo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; m_stb = '0; m_we = '0; s_ack = 1'b0; s_stall = 1'b0; s_rdata = '0;
    for (int n = 0; n < 2; n++) begin
      m_addr[n] = '0; m_wdata[n] = '0; m_sel[n] = '0;
    end
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " s_stb"},  s_stb,  0);
    chk({tag, " s_we"},   s_we,   0);
    chk({tag, " s_addr"}, s_addr, 32'hFFFF_FFFF);
    chk({tag, " s_data"}, s_data, 32'hFFFF_FFFF);
    chk({tag, " s_sel"},  s_sel,  0);
    chk({tag, " m0_data"}, m0_rd, 32'hFFFF_FFFF);
    chk({tag, " m1_data"}, m1_rd, 32'hFFFF_FFFF);
    chk({tag, " acks"},   ack_v,   0);
    chk({tag, " stalls"}, stall_v, 0);
    chk({tag, " grant"},  grant,  0);
    chk({tag, " busy"},   busy,   0);
    chk({tag, " timeout"}, tmo_o, 0);
  endtask

  // Acks every request immediately, no new master traffic.
  task automatic drain(input int n);
    m_stb = '0;
    for (int i = 0; i < n; i++) begin
      s_ack = s_stb; s_rdata = 32'h0;
      tick();
    end
    s_ack = 1'b0;
  endtask

  task automatic put_req(input bit m, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
    m_stb[m] = 1'b1; m_we[m] = we; m_addr[m] = a; m_wdata[m] = d; m_sel[m] = s;
  endtask

  vec_t vecs [5];

  // random-phase model state
  req_t        mreq [2];
  req_t        capreq [2];
  req_t        cur;
  bit          mpend [2];
  bit          cap_prev [2];
  bit          mbusy, mlast, mgrant, stall_prev, ackd_prev, comp, tmo, iss, g, m;
  int          wcnt, ack_in, r, ng;
  logic [31:0] mdata [2];
  logic [31:0] ackd_data;
  logic [1:0]  exp_ack;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          3'd2, 32'h0000_0013,  0, 32'h0000_0013, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D,  3'd2, 32'h0000_0000,  1, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_7FFC, 32'h0BAD_C0DE,  3'd0, 32'h1111_1111,  2, 32'h1111_1111, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          3'd4, 32'h0000_0000, -1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          3'd5, 32'h0000_0000,  0, 32'h0000_0000, 1'b0};

    do_reset();
    chk_rst("reset");

    // ---------------- vector table: isolated transactions ----------------
    for (int i = 0; i < 5; i++) begin
      m = vecs[i].m;
      put_req(m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel);
      tick();
      m_stb = '0;
      chk("tbl stall_up", stall_v[m], 1);
      chk("tbl s_stb_early", s_stb, 0);
      tick();
      chk("tbl s_stb", s_stb, 1);
      chk("tbl grant", grant, m);
      chk("tbl s_we", s_we, vecs[i].we);
      chk("tbl s_addr", s_addr, vecs[i].addr);
      chk("tbl s_data", s_data, vecs[i].wdata);
      chk("tbl s_sel", s_sel, vecs[i].sel);
      chk("tbl busy", busy, 1);
      if (vecs[i].dly >= 0) begin
        repeat (vecs[i].dly) tick();
        s_ack = 1'b1; s_rdata = vecs[i].rdata;
        tick();
        s_ack = 1'b0;
      end else begin
        repeat (TMO - 1) tick();
        chk("tbl no_early_ack", ack_v[m], 0);
        tick();
      end
      chk("tbl ack", ack_v[m], 1);
      chk("tbl other_ack", ack_v[!m], 0);
      chk("tbl rdata", rd_v[m], vecs[i].exp_data);
      chk("tbl timeout", tmo_o, vecs[i].exp_to);
      chk("tbl stall_down", stall_v[m], 0);
      chk("tbl busy_done", busy, 0);
      tick();
      chk("tbl ack_width", ack_v[m], 0);
      chk("tbl rdata_hold", rd_v[m], vecs[i].exp_data);
      chk("tbl timeout_width", tmo_o, 0);
    end

    // ---------------- contention right after reset ----------------
    do_reset();
    put_req(1'b0, 1'b0, 32'h0, 32'h0, 3'd2);
    put_req(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 3'd2);
    tick();
    m_stb = '0;
    tick();
    chk("tie s_stb0", s_stb, 1);
    chk("tie grant0", grant, 0);
    chk("tie addr0", s_addr, 32'h0);
    chk("tie we0", s_we, 0);
    s_ack = 1'b1; s_rdata = 32'h0000_00A0;
    tick();
    s_ack = 1'b0;
    chk("tie m0_ack", ack_v, 2'b01);
    chk("tie m0_data", m0_rd, 32'h0000_00A0);
    tick();
    chk("tie s_stb1", s_stb, 1);
    chk("tie grant1", grant, 1);
    chk("tie we1", s_we, 1);
    chk("tie addr1", s_addr, 32'h40);
    chk("tie data1", s_data, 32'hDEAD_BEEF);
    s_ack = 1'b1; s_rdata = 32'h0;
    tick();
    s_ack = 1'b0;
    chk("tie m1_ack", ack_v, 2'b10);

    // ---------------- both masters re-strobe on every ack ----------------
    put_req(1'b0, 1'b0, 32'h100, 32'h0, 3'd2);
    put_req(1'b1, 1'b0, 32'h200, 32'h0, 3'd2);
    tick();
    ng = 0;
    for (int c = 0; c < 100 && ng < 8; c++) begin
      m_stb = '0; s_ack = 1'b0;
      if (s_stb) begin
        chk("rr grant", grant, ng % 2);
        ng++;
        s_ack = 1'b1; s_rdata = ng;
      end
      for (int n = 0; n < 2; n++) begin
        if (ack_v[n] && ng < 8) put_req(n[0], 1'b0, 32'h100 * (n + 1), 32'h0, 3'd2);
      end
      tick();
    end
    chk("rr count", ng, 8);
    drain(20);
    chk("rr drained", busy, 0);

    // ---------------- slave stall holds off the issue ----------------
    s_stall = 1'b1;
    put_req(1'b1, 1'b0, 32'h300, 32'h0, 3'd1);
    tick();
    m_stb = '0;
    for (int k = 0; k < 5; k++) begin
      chk("stall s_stb", s_stb, 0);
      chk("stall m1", m1_stall, 1);
      if (k == 4) s_stall = 1'b0;
      tick();
    end
    chk("stall release", s_stb, 1);
    chk("stall grant", grant, 1);
    s_ack = 1'b1; s_rdata = 32'h7;
    tick();
    s_ack = 1'b0;
    chk("stall m1_ack", m1_ack, 1);

    // ---------------- timeout, then a late ack ----------------
    put_req(1'b0, 1'b0, 32'h20, 32'h0, 3'd2);
    tick();
    m_stb = '0;
    tick();
    chk("to s_stb", s_stb, 1);
    repeat (TMO - 1) tick();
    chk("to early_ack", m0_ack, 0);
    chk("to early_pulse", tmo_o, 0);
    tick();
    chk("to ack", m0_ack, 1);
    chk("to data", m0_rd, 32'hFFFF_FFFF);
    chk("to pulse", tmo_o, 1);
    s_ack = 1'b1; s_rdata = 32'h1234;
    tick();
    s_ack = 1'b0;
    chk("to late_ack", ack_v, 0);
    chk("to pulse_width", tmo_o, 0);
    chk("to data_hold", m0_rd, 32'hFFFF_FFFF);
    chk("to busy", busy, 0);

    // ---------------- reset while waiting on the slave ----------------
    put_req(1'b0, 1'b1, 32'h44, 32'h5555_AAAA, 3'd2);
    tick();
    m_stb = '0;
    tick();
    chk("rstw s_stb", s_stb, 1);
    rst = 1'b1;
    tick();
    chk_rst("rstw");
    rst = 1'b0; s_ack = 1'b1; s_rdata = 32'h9999;
    tick();
    s_ack = 1'b0;
    chk("rstw late_ack", ack_v, 0);
    chk("rstw s_stb_after", s_stb, 0);
    put_req(1'b1, 1'b0, 32'h80, 32'h0, 3'd2);
    tick();
    m_stb = '0;
    tick();
    chk("rstw m1_s_stb", s_stb, 1);
    chk("rstw m1_grant", grant, 1);
    chk("rstw m1_addr", s_addr, 32'h80);
    s_ack = 1'b1; s_rdata = 32'h55AA;
    tick();
    s_ack = 1'b0;
    chk("rstw m1_ack", m1_ack, 1);
    chk("rstw m1_data", m1_rd, 32'h55AA);

    // ---------------- randomized traffic vs. rule model ----------------
    do_reset();
    for (int n = 0; n < 2; n++) begin
      mpend[n] = 1'b0; cap_prev[n] = 1'b0; mdata[n] = 32'hFFFF_FFFF;
      mreq[n] = '0; capreq[n] = '0;
    end
    cur = '0;
    mbusy = 1'b0; mlast = 1'b1; mgrant = 1'b0;
    stall_prev = 1'b0; ackd_prev = 1'b0; ackd_data = '0;
    wcnt = 0; ack_in = -1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      comp = 1'b0; tmo = 1'b0; iss = 1'b0; g = 1'b0;
      if (mbusy) begin
        wcnt++;
        if (ackd_prev) comp = 1'b1;
        else if (wcnt == TMO) begin comp = 1'b1; tmo = 1'b1; end
      end else if ((mpend[0] || mpend[1]) && !stall_prev) begin
        iss = 1'b1;
        g = (mpend[0] && mpend[1]) ? !mlast : mpend[1];
      end
      exp_ack = '0;
      if (comp) begin
        exp_ack[mgrant] = 1'b1;
        mdata[mgrant]   = tmo ? 32'hFFFF_FFFF : ackd_data;
        mpend[mgrant]   = 1'b0;
        mlast           = mgrant;
        mbusy           = 1'b0;
      end
      if (iss) begin
        mgrant = g; mbusy = 1'b1; wcnt = 0; cur = mreq[g];
      end
      for (int n = 0; n < 2; n++) begin
        if (cap_prev[n]) begin mpend[n] = 1'b1; mreq[n] = capreq[n]; end
      end

      chk("rnd s_stb", s_stb, iss);
      chk("rnd grant", grant, mgrant);
      chk("rnd busy", busy, mbusy);
      chk("rnd timeout", tmo_o, tmo);
      for (int n = 0; n < 2; n++) begin
        chk("rnd ack", ack_v[n], exp_ack[n]);
        chk("rnd rdata", rd_v[n], mdata[n]);
        chk("rnd stall", stall_v[n], mpend[n]);
      end
      if (iss) begin
        chk("rnd s_we", s_we, cur.we);
        chk("rnd s_addr", s_addr, cur.addr);
        chk("rnd s_data", s_data, cur.data);
        chk("rnd s_sel", s_sel, cur.sel);
      end

      // slave behaviour
      s_ack = 1'b0; s_rdata = $urandom;
      if (iss) begin
        r = $urandom_range(0, 6);
        ack_in = (r == 6) ? -1 : r % 3;
      end
      if (mbusy && ack_in == 0) begin
        s_ack = 1'b1; ack_in = -1;
      end else if (mbusy && ack_in > 0) begin
        ack_in--;
      end else if (comp && tmo && $urandom_range(0, 1) == 1) begin
        s_ack = 1'b1;   // stale ack after a timeout
      end
      s_stall    = ($urandom_range(0, 3) == 0);
      ackd_prev  = s_ack;
      ackd_data  = s_rdata;
      stall_prev = s_stall;

      // master behaviour: strobes also land while stalled and must be dropped
      for (int n = 0; n < 2; n++) begin
        m_stb[n]   = ($urandom_range(0, 2) != 0);
        m_we[n]    = $urandom_range(0, 1) == 1;
        m_addr[n]  = $urandom;
        m_wdata[n] = $urandom;
        m_sel[n]   = 3'($urandom_range(0, 7));
        cap_prev[n] = m_stb[n] && !mpend[n];
        capreq[n]   = '{m_we[n], m_addr[n], m_wdata[n], m_sel[n]};
      end
    end
    m_stb = '0; s_ack = 1'b0; s_stall = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
